// File: rtl/apb_simple_master_if.sv
// APB3 bus bundle between the simple APB master and the slave select fabric.
//
// Signals:
//   PADDR, PWDATA, PWRITE, PSEL, PENABLE  master -> slave
//   PRDATA, PREADY, PSLVERR               slave  -> master
// Modports: master (initiator side), slave (peripheral side).
interface apb_simple_master_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
) ();

  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR,
    output PWDATA,
    output PWRITE,
    output PSEL,
    output PENABLE,
    input  PRDATA,
    input  PREADY,
    input  PSLVERR
  );

  modport slave (
    input  PADDR,
    input  PWDATA,
    input  PWRITE,
    input  PSEL,
    input  PENABLE,
    output PRDATA,
    output PREADY,
    output PSLVERR
  );

endinterface

// File: rtl/apb_simple_master.sv
// APB3 initiator: turns a single-outstanding req/gnt/rvalid port into APB transfers.
// One transfer in flight; wait states via PREADY, slave errors via PSLVERR.
//
// Ports:
//   HCLK, HRESETn        clock (rising edge), asynchronous active-low reset
//   req_i/addr_i/we_i/wdata_i  request; accepted when gnt_o is high (IDLE only)
//   gnt_o                request accepted this cycle (combinational from req_i)
//   rvalid_o             one-cycle response pulse
//   rdata_o, err_o       response data (0 for writes) and error; held until next response
//   apb                  APB3 master bundle (apb_simple_master_if.master)
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles with PREADY low (response then carries err_o=1, rdata_o=0).
module apb_simple_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  apb_simple_master_if.master       apb
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rvalid_q, rvalid_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntBits = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW    = (CntBits > 8) ? CntBits : 8;

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StSetup) begin
      wait_cnt_d = '0;
    end else if (state_q == StAccess && !apb.PREADY) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th consecutive ACCESS cycle with PREADY low.
  assign timeout = (state_q == StAccess) && !apb.PREADY &&
                   (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_o = req_i;
        if (req_i) begin
          paddr_d  = addr_i;
          pwdata_d = wdata_i;
          pwrite_d = we_i;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        // A ready slave wins over a timeout landing in the same cycle.
        if (apb.PREADY) begin
          state_d  = StIdle;
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? 32'h0 : apb.PRDATA;
          err_d    = apb.PSLVERR;
        end else if (timeout) begin
          state_d  = StIdle;
          rvalid_d = 1'b1;
          rdata_d  = 32'h0;
          err_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Select/enable decode straight from state so reset drops them immediately.
  assign apb.PSEL    = (state_q != StIdle);
  assign apb.PENABLE = (state_q == StAccess);
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_apb_simple_master.sv
`timescale 1ns / 1ps
module tb_apb_simple_master;

  localparam int unsigned AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   wdata_i, rdata_o;
  logic          gnt_o, rvalid_o, err_o;

  always #5 HCLK = ~HCLK;

  apb_simple_master_if #(.APB_ADDR_WIDTH(AW)) apb ();

  apb_simple_master #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req_i   (req_i),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .wdata_i (wdata_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .apb     (apb)
  );

  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [31:0]   wdata;
    int          waits;
    bit          slverr;
    bit          hold;
    bit [31:0]   exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  // Scratch-register slave storage (written from observed APB writes) and the
  // reference model's view (written from accepted requests).
  bit [31:0] slave_mem [bit [AW-1:0]];
  bit [31:0] ref_mem   [bit [AW-1:0]];

  function automatic bit [31:0] dflt(input bit [AW-1:0] a);
    return 32'hDEAD_0000 | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request starting in the current (IDLE) cycle, plays the slave,
  // and checks APB protocol every cycle until the response.
  task automatic xfer(input bit we, input bit [AW-1:0] addr, input bit [31:0] wdata,
                      input int waits, input bit slverr, input bit hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int  acc;
    bit  done;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    #1;
    chk("gnt_idle", gnt_o, 1);
    acc  = 0;
    done = 0;
    lat  = -1;
    rd   = '0;
    er   = 1'b0;
    for (int c = 1; c <= 300 && !done; c++) begin
      @(posedge HCLK);
      #1;
      apb.PREADY  = 1'b0;
      apb.PSLVERR = 1'b0;
      apb.PRDATA  = $urandom;
      if (!hold) begin
        req_i   = 1'b0;
        we_i    = 1'($urandom);
        addr_i  = AW'($urandom);
        wdata_i = $urandom;
      end
      @(negedge HCLK);
      if (rvalid_o) begin
        done = 1;
        lat  = c;
        rd   = rdata_o;
        er   = err_o;
        chk("psel_resp", apb.PSEL, 0);
        chk("penable_resp", apb.PENABLE, 0);
        chk("gnt_resp", gnt_o, req_i);
        chk("paddr_hold", apb.PADDR, 32'(addr));
      end else begin
        chk("rdata_hold", rdata_o, last_rdata);
        chk("err_hold", err_o, last_err);
        chk("gnt_busy", gnt_o, 0);
        chk("psel", apb.PSEL, 1);
        chk("penable", apb.PENABLE, (c >= 2) ? 1 : 0);
        chk("paddr", apb.PADDR, 32'(addr));
        chk("pwrite", apb.PWRITE, we);
        chk("pwdata", apb.PWDATA, wdata);
        if (apb.PSEL && apb.PENABLE) begin
          if (acc < waits) begin
            acc++;
            apb.PSLVERR = 1'($urandom);
          end else begin
            apb.PREADY  = 1'b1;
            apb.PSLVERR = slverr;
            if (apb.PWRITE) begin
              if (!slverr) slave_mem[apb.PADDR] = apb.PWDATA;
            end else begin
              apb.PRDATA = slave_mem.exists(apb.PADDR) ? slave_mem[apb.PADDR] : dflt(apb.PADDR);
            end
          end
        end
      end
    end
    if (!done) chk("rvalid_timeout", 0, 1);
    apb.PREADY = 1'b0;
    last_rdata = rd;
    last_err   = er;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(v.we, v.addr, v.wdata, v.waits, v.slverr, v.hold, rd, er, lat);
    chk({name, "_lat"}, 32'(lat), 32'(v.exp_lat));
    chk({name, "_rdata"}, rd, v.exp_rdata);
    chk({name, "_err"}, er, v.exp_err);
    if (v.we && !v.slverr) ref_mem[v.addr] = v.wdata;
  endtask

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{0, 12'h100, 32'h0,         0, 0, 0, 32'hCAFE_0001, 0, 3};
    vecs[1] = '{1, 12'h004, 32'h1234_5678, 0, 0, 0, 32'h0,         0, 3};
    vecs[2] = '{0, 12'h004, 32'h0,         0, 0, 0, 32'h1234_5678, 0, 3};
    vecs[3] = '{0, 12'h004, 32'h0,         3, 0, 1, 32'h1234_5678, 0, 6};
    vecs[4] = '{0, 12'h004, 32'h0,         0, 0, 0, 32'h1234_5678, 0, 3};
    vecs[5] = '{0, 12'h008, 32'h0,         0, 1, 0, 32'hDEAD_0008, 1, 3};
    vecs[6] = '{1, 12'h010, 32'hAABB_CCDD, 1, 0, 0, 32'h0,         0, 4};
    vecs[7] = '{1, 12'h020, 32'h5555_AAAA, 0, 1, 0, 32'h0,         1, 3};
    slave_mem[12'h100] = 32'hCAFE_0001;
    ref_mem[12'h100]   = 32'hCAFE_0001;

    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0;
    apb.PRDATA = '0; apb.PREADY = 0; apb.PSLVERR = 0;

    // Reset state
    #12;
    chk("rst_psel", apb.PSEL, 0);
    chk("rst_penable", apb.PENABLE, 0);
    chk("rst_pwrite", apb.PWRITE, 0);
    chk("rst_paddr", apb.PADDR, 0);
    chk("rst_pwdata", apb.PWDATA, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Directed table (vecs[3] holds req_i so vecs[4] is granted in its response cycle)
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Randomized transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      v.we     = 1'($urandom);
      v.addr   = AW'($urandom_range(0, 7) * 4);
      v.wdata  = $urandom;
      v.waits  = $urandom_range(0, 3);
      v.slverr = ($urandom_range(0, 5) == 0);
      v.hold   = 0;
      v.exp_lat   = 3 + v.waits;
      v.exp_err   = v.slverr;
      v.exp_rdata = v.we ? 32'h0 : (ref_mem.exists(v.addr) ? ref_mem[v.addr] : dflt(v.addr));
      run_vec($sformatf("rnd%0d", i), v);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        chk("gap_rvalid", rvalid_o, 0);
        chk("gap_psel", apb.PSEL, 0);
        chk("gap_gnt", gnt_o, 0);
      end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave: 4 ACCESS cycles with PREADY low, then abort with error.
    run_vec("timeout", '{0, 12'h00C, 32'h0, 1000, 0, 0, 32'h0, 1, 6});
`endif

    // Reset asserted mid-ACCESS
    req_i = 1; we_i = 0; addr_i = 12'h004; wdata_i = 32'h0;
    @(posedge HCLK);
    #1;
    req_i = 0;
    @(posedge HCLK);
    @(negedge HCLK);
    chk("midrst_in_access", apb.PENABLE, 1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midrst_psel", apb.PSEL, 0);
    chk("midrst_penable", apb.PENABLE, 0);
    chk("midrst_paddr", apb.PADDR, 0);
    chk("midrst_rvalid", rvalid_o, 0);
    chk("midrst_rdata", rdata_o, 0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    last_rdata = '0;
    last_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("postrst_no_rvalid", rvalid_o, 0);
    end
    v = '{0, 12'h004, 32'h0, 0, 0, 0, 32'h1234_5678, 0, 3};
    v.exp_rdata = ref_mem[12'h004];
    run_vec("postrst", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_simple_master.md
# apb_simple_master

APB initiator that converts a single-outstanding request/grant/response port into APB3 transfers toward the peripheral slaves (4 KB windows). Sits between a core-side request source (debug bridge, test controller, small DMA) and the APB slave select fabric. One transfer in flight at a time. Wait states (PREADY) and slave errors (PSLVERR) are reported back on the response port.

## Interface
- APB_ADDR_WIDTH, 12, width of addr_i and PADDR
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles with PREADY low before abort (used only with timeout compiled in)

- HCLK  in  1  clock; all logic rising-edge
- HRESETn  in  1  reset, asynchronous, active-low
- req_i  in  1  request valid
- addr_i  in  APB_ADDR_WIDTH  byte address
- we_i  in  1  1 = write, 0 = read
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid, one-cycle pulse
- rdata_o  out  32  read data (0 for writes)
- err_o  out  1  error flag, valid with rvalid_o
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: gnt_o = req_i (combinational). On req_i=1, addr_i/we_i/wdata_i captured into PADDR/PWRITE/PWDATA; next SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally next ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY=0 -> stay. PREADY=1 -> next IDLE; rdata_o <= PRDATA if read else 0; err_o <= PSLVERR; rvalid_o <= 1.
- gnt_o=0 in SETUP and ACCESS; requests there are not accepted and must be held by the source.
- PADDR, PWDATA, PWRITE stable from SETUP through last ACCESS cycle; hold last value in IDLE.
- rdata_o and err_o hold last response value until the next response; rvalid_o high exactly one cycle per accepted request.
- PRDATA and PSLVERR sampled only in the ACCESS cycle with PREADY=1.

## Timing
- Reset (HRESETn=0, any state incl. mid-ACCESS): state IDLE; PSEL, PENABLE, PWRITE, rvalid_o, err_o = 0; PADDR, PWDATA, rdata_o = 0; any in-flight transfer dropped, no response. gnt_o = req_i once in IDLE.
- Zero-wait transfer: grant at cycle 0, SETUP cycle 1, ACCESS cycle 2 (PREADY=1), rvalid_o cycle 3.
- N wait states add N cycles: rvalid_o at cycle 3+N.
- Back-to-back: cycle with rvalid_o=1 is IDLE; a request then is granted the same cycle. Peak rate one transfer per 3 cycles.
- PSEL never deasserts between SETUP and completing ACCESS; PENABLE never high without PSEL.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: 8-bit-or-wider counter, cleared on entering ACCESS, incremented each ACCESS cycle with PREADY=0. When count reaches TIMEOUT_CYCLES with PREADY still 0: next IDLE, PSEL/PENABLE drop, rvalid_o=1, err_o=1, rdata_o=0. PREADY=1 in that same cycle wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely for PREADY; TIMEOUT_CYCLES ignored.

## Test plan
- Read, slave PREADY=1, PRDATA=0xCAFE_0001, PSLVERR=0 -> PSEL cycles 1-2, PENABLE cycle 2, rvalid_o cycle 3, rdata_o=0xCAFE_0001, err_o=0.
- Write addr 0x004, wdata 0x1234_5678, then read 0x004 from scratch-register slave -> PWRITE=1 with PWDATA=0x1234_5678 during SETUP/ACCESS; read returns 0x1234_5678; write response rdata_o=0.
- Read with PREADY low 3 ACCESS cycles -> PADDR/PSEL/PENABLE stable, rvalid_o at cycle 6; req_i held throughout gets gnt_o only at cycle 6.
- PSLVERR=1 with PREADY=1 -> rvalid_o with err_o=1; next request granted same cycle.
- APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 wait cycles, rvalid_o=1, err_o=1, rdata_o=0, PSEL=0 next cycle.
- HRESETn asserted mid-ACCESS -> PSEL/PENABLE=0 immediately, no rvalid_o; after release, new read completes normally in 3 cycles.
